// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: FSM state codes, opcode defaults, issue timeout.
package seq_pkg;

   localparam int OPW_DEF = 20;
   localparam logic [OPW_DEF-1:0] HALT_OPCODE_DEF = {OPW_DEF{1'b1}};

   // Number of consecutive Done-high samples (issue edge included) treated as acceptance.
   localparam logic [1:0] ISSUE_TIMEOUT = 2'd2;

   typedef logic [2:0] seqState_t;

   localparam seqState_t S_IDLE      = 3'd0;
   localparam seqState_t S_FETCH     = 3'd1;
   localparam seqState_t S_ISSUE     = 3'd2;
   localparam seqState_t S_WAIT_BUSY = 3'd3;
   localparam seqState_t S_WAIT_DONE = 3'd4;
   localparam seqState_t S_HALT      = 3'd5;

endpackage

// File: rtl/seq_prog_ram.sv
// Program store: DEPTH x OPW RAM, one write port and one registered read port (1-cycle latency).
module seq_prog_ram #(
   parameter int OPW = 20,
   parameter int AW  = 5
) (
   input  logic           Clock,
   input  logic           WrEn,
   input  logic [AW-1:0]  WrAddr,
   input  logic [OPW-1:0] WrData,
   input  logic [AW-1:0]  RdAddr,
   output logic [OPW-1:0] RdData
);

   logic [OPW-1:0] mem [2**AW];

   // Contents deliberately survive reset so a loaded program can be rerun.
   always_ff @(posedge Clock) begin
      if (WrEn) begin
         mem[WrAddr] <= WrData;
      end
      RdData <= mem[RdAddr];
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches opcodes from the program RAM and issues them one at a time to the Excutor.
// Build option: define SEQ_LOOP_EN to wrap Pc to 0 at end of program instead of halting.
module instruction_sequencer
   import seq_pkg::*;
#(
   parameter int             OPW         = OPW_DEF,
   parameter int             AW          = 5,
   parameter logic [OPW-1:0] HALT_OPCODE = {OPW{1'b1}}
) (
   input  logic           Clock,
   input  logic           ResetN,
   input  logic           LoadEn,
   input  logic [AW-1:0]  LoadAddr,
   input  logic [OPW-1:0] LoadData,
   input  logic [AW:0]    ProgLen,
   input  logic           Start,
   input  logic           Stop,
   input  logic           Done,
   output logic [OPW-1:0] OpCode,
   output logic           Issue,
   output logic [AW-1:0]  Pc,
   output logic           Busy,
   output logic           Finished,
   output logic [AW:0]    InstrCount,
   output seqState_t      DbgState
);

   // Issue/Done handshake: Issue is a one-cycle strobe qualifying OpCode; the Excutor accepts by
   // dropping Done and completes by raising it again. Done held high across the issue edge and the
   // following edge means the op finished within the Issue cycle.

   seqState_t      state;
   logic [OPW-1:0] ramData;
   logic           stopReq;
   logic [1:0]     tmoCnt;
   logic           progEnd;
   logic           countSat;
   logic [AW:0]    progLenLast;

   seq_prog_ram #(
      .OPW (OPW),
      .AW  (AW)
   ) progRam (
      .Clock  (Clock),
      .WrEn   (LoadEn && !Busy),
      .WrAddr (LoadAddr),
      .WrData (LoadData),
      .RdAddr (Pc),
      .RdData (ramData)
   );

   assign progLenLast = ProgLen - {{AW{1'b0}}, 1'b1};
   assign progEnd     = ((ProgLen != '0) && ({1'b0, Pc} == progLenLast)) || (Pc == '1);
   assign countSat    = (InstrCount == '1);
   assign DbgState    = state;

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state      <= S_IDLE;
         OpCode     <= '0;
         Issue      <= 1'b0;
         Pc         <= '0;
         Busy       <= 1'b0;
         Finished   <= 1'b0;
         InstrCount <= '0;
         stopReq    <= 1'b0;
         tmoCnt     <= '0;
      end else begin
         Issue <= 1'b0;
         if (Busy && Stop) begin
            stopReq <= 1'b1;
         end
         case (state)
            S_IDLE, S_HALT: begin
               if (Start) begin
                  Pc         <= '0;
                  InstrCount <= '0;
                  Busy       <= 1'b1;
                  Finished   <= 1'b0;
                  stopReq    <= 1'b0;
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (ramData == HALT_OPCODE) begin
                  Busy     <= 1'b0;
                  Finished <= 1'b1;
                  stopReq  <= 1'b0;
                  state    <= S_HALT;
               end else begin
                  OpCode <= ramData;
                  Issue  <= 1'b1;
                  if (!countSat) begin
                     InstrCount <= InstrCount + 1'b1;
                  end
                  tmoCnt <= Done ? 2'd1 : 2'd0;
                  state  <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (!Done || (tmoCnt >= ISSUE_TIMEOUT - 2'd1)) begin
                  state <= S_WAIT_DONE;
               end else begin
                  tmoCnt <= tmoCnt + 2'd1;
               end
            end
            S_WAIT_DONE: begin
               if (Done) begin
                  if (stopReq || Stop) begin
                     Busy     <= 1'b0;
                     Finished <= 1'b1;
                     stopReq  <= 1'b0;
                     state    <= S_HALT;
                  end else if (progEnd) begin
`ifdef SEQ_LOOP_EN
                     Pc    <= '0;
                     state <= S_FETCH;
`else
                     Busy     <= 1'b1 & 1'b0;
                     Finished <= 1'b1;
                     state    <= S_HALT;
`endif
                  end else begin
                     Pc    <= Pc + 1'b1;
                     state <= S_FETCH;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: randomized programs against a program-level model.
module tb_instruction_sequencer;

   localparam int OPW = 20;
   localparam int AW = 5;
   localparam int DEPTH = 32;
   localparam logic [OPW-1:0] HALT_OP = {OPW{1'b1}};

   logic Clock = 1'b0;
   logic ResetN = 1'b0;
   logic LoadEn = 1'b0;
   logic [AW-1:0] LoadAddr = '0;
   logic [OPW-1:0] LoadData = '0;
   logic [AW:0] ProgLen = '0;
   logic Start = 1'b0;
   logic Stop = 1'b0;
   logic Done = 1'b1;
   logic [OPW-1:0] OpCode;
   logic Issue;
   logic [AW-1:0] Pc;
   logic Busy;
   logic Finished;
   logic [AW:0] InstrCount;
   logic [2:0] DbgState;

   int checks = 0;
   int failures = 0;

   logic [OPW-1:0] model_mem [DEPTH];
   logic [OPW-1:0] exp_q[$];
   logic [AW-1:0] exp_pc_q[$];
   int exp_count;
   logic [AW-1:0] exp_final_pc;
   logic [OPW-1:0] obs_op[$];
   logic [AW-1:0] obs_pc[$];
   int obs_cyc[$];

   int opt_start_idx;
   bit opt_load_attack;
   bit opt_stop_at_start;
   bit opt_load_at_start;
   logic [OPW-1:0] opt_load_val;

   instruction_sequencer dut (
      .Clock(Clock), .ResetN(ResetN), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
      .ProgLen(ProgLen), .Start(Start), .Stop(Stop), .Done(Done), .OpCode(OpCode), .Issue(Issue),
      .Pc(Pc), .Busy(Busy), .Finished(Finished), .InstrCount(InstrCount), .DbgState(DbgState)
   );

   always #5 Clock = ~Clock;

   function automatic logic [OPW-1:0] rand_op();
      return OPW'($urandom_range(0, 32'hFFFFE));
   endfunction

   // Program-level reference: walk the program by its rules, not by cycles.
   function automatic void build_expected(input int prog_len, input int stop_idx);
      int pc = 0;
      int n = 0;
      exp_q.delete();
      exp_pc_q.delete();
      for (int guard = 0; guard < 1000; guard++) begin
         if (model_mem[pc] == HALT_OP) break;
         exp_q.push_back(model_mem[pc]);
         exp_pc_q.push_back(AW'(pc));
         n++;
         if (n == stop_idx + 1) break;
`ifdef SEQ_LOOP_EN
         if ((prog_len != 0 && pc + 1 == prog_len) || pc == DEPTH - 1) pc = 0;
         else pc++;
`else
         if ((prog_len != 0 && n == prog_len) || pc == DEPTH - 1) break;
         pc++;
`endif
      end
      exp_count = (n > 63) ? 63 : n;
      exp_final_pc = AW'(pc);
   endfunction

   task automatic clear_opts();
      opt_start_idx = -1;
      opt_load_attack = 0;
      opt_stop_at_start = 0;
      opt_load_at_start = 0;
      opt_load_val = '0;
   endtask

   task automatic load_prog();
      for (int a = 0; a < DEPTH; a++) begin
         LoadEn = 1'b1;
         LoadAddr = AW'(a);
         LoadData = model_mem[a];
         @(negedge Clock);
      end
      LoadEn = 1'b0;
   endtask

   // Drives Start, plays the Excutor (Done low for low_cycles after each Issue, 0 = always high),
   // and records every issued opcode until Finished or the cycle budget runs out.
   task automatic run_prog(input int prog_len, input int stop_idx, input int low_cycles, input int budget);
      int left = 0;
      int n_issue = 0;
      int cycles = 0;
      obs_op.delete();
      obs_pc.delete();
      obs_cyc.delete();
      ProgLen = (AW+1)'(prog_len);
      Done = 1'b1;
      Start = 1'b1;
      Stop = opt_stop_at_start;
      if (opt_load_at_start) begin
         LoadEn = 1'b1;
         LoadAddr = '0;
         LoadData = opt_load_val;
      end
      @(negedge Clock);
      while (Finished !== 1'b1 && cycles < budget) begin
         Stop = 1'b0;
         Start = 1'b0;
         LoadEn = 1'b0;
         if (opt_load_attack && cycles == 0) begin
            LoadEn = 1'b1;
            LoadAddr = AW'(1);
            LoadData = model_mem[1] ^ 20'h5A5A5;
         end
         if (Issue === 1'b1) begin
            obs_op.push_back(OpCode);
            obs_pc.push_back(Pc);
            obs_cyc.push_back(cycles);
            if (n_issue == stop_idx) Stop = 1'b1;
            if (n_issue == opt_start_idx) Start = 1'b1;
            n_issue++;
            if (low_cycles > 0) begin
               Done = 1'b0;
               left = low_cycles;
            end
         end else if (left > 0) begin
            left--;
            if (left == 0) Done = 1'b1;
         end
         @(negedge Clock);
         cycles++;
      end
      Stop = 1'b0;
      Start = 1'b0;
      LoadEn = 1'b0;
      Done = 1'b1;
      checks++;
      if (Finished !== 1'b1) begin
         failures++;
         $display("FAIL run_finish: Finished=%b after %0d cycles, required 1", Finished, cycles);
      end
   endtask

   task automatic test_reset();
      ResetN = 1'b0;
      repeat (3) @(negedge Clock);
      checks += 6;
      if (OpCode !== '0) begin failures++; $display("FAIL reset_opcode: got %h want 0", OpCode); end
      if (Issue !== 1'b0) begin failures++; $display("FAIL reset_issue: got %b want 0", Issue); end
      if (Pc !== '0) begin failures++; $display("FAIL reset_pc: got %0d want 0", Pc); end
      if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
      if (Finished !== 1'b0) begin failures++; $display("FAIL reset_finished: got %b want 0", Finished); end
      if (InstrCount !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", InstrCount); end
      ResetN = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_basic();
      clear_opts();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_op();
      load_prog();
      build_expected(3, -1);
      run_prog(3, -1, 3, 200);
      checks++;
      if (obs_op.size() != exp_q.size()) begin
         failures++; $display("FAIL basic_issues: got %0d want %0d", obs_op.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_op.size()) begin
         checks++;
         if (obs_op[i] !== exp_q[i] || obs_pc[i] !== exp_pc_q[i]) begin
            failures++;
            $display("FAIL basic_op%0d: got %h@%0d want %h@%0d", i, obs_op[i], obs_pc[i], exp_q[i], exp_pc_q[i]);
         end
      end
      checks += 3;
      if (InstrCount !== 6'd3) begin failures++; $display("FAIL basic_count: got %0d want 3", InstrCount); end
      if (Pc !== 5'd2) begin failures++; $display("FAIL basic_pc: got %0d want 2", Pc); end
      if (Busy !== 1'b0 || OpCode !== exp_q[2]) begin
         failures++; $display("FAIL basic_hold: busy=%b op=%h want busy=0 op=%h", Busy, OpCode, exp_q[2]);
      end
   endtask

   task automatic test_halt_opcode();
      clear_opts();
      model_mem[0] = rand_op();
      model_mem[1] = HALT_OP;
      model_mem[2] = rand_op();
      load_prog();
      build_expected(0, -1);
      run_prog(0, -1, 2, 200);
      checks += 4;
      if (obs_op.size() != 1 || obs_op[0] !== model_mem[0]) begin
         failures++; $display("FAIL halt_op_issues: got %0d issues want 1 of %h", obs_op.size(), model_mem[0]);
      end
      if (Pc !== 5'd1) begin failures++; $display("FAIL halt_op_pc: got %0d want 1", Pc); end
      if (InstrCount !== 6'd1) begin failures++; $display("FAIL halt_op_count: got %0d want 1", InstrCount); end
      if (OpCode !== model_mem[0]) begin failures++; $display("FAIL halt_op_hold: got %h want %h", OpCode, model_mem[0]); end
   endtask

   task automatic test_stop();
      logic [OPW-1:0] saved1;
      clear_opts();
      opt_start_idx = 0;
      opt_load_attack = 1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_op();
      saved1 = model_mem[1];
      load_prog();
      build_expected(5, 1);
      run_prog(5, 1, 3, 300);
      checks += 4;
      if (obs_op.size() != 2) begin failures++; $display("FAIL stop_issues: got %0d want 2", obs_op.size()); end
      else if (obs_op[1] !== saved1 || obs_pc[1] !== 5'd1 || obs_pc[0] !== 5'd0) begin
         failures++; $display("FAIL stop_trace: got %h@%0d want %h@1", obs_op[1], obs_pc[1], saved1);
      end
      if (InstrCount !== (AW+1)'(exp_count)) begin failures++; $display("FAIL stop_count: got %0d want %0d", InstrCount, exp_count); end
      if (Pc !== exp_final_pc) begin failures++; $display("FAIL stop_pc: got %0d want %0d", Pc, exp_final_pc); end
      if (Finished !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL stop_flags: fin=%b busy=%b want 1 0", Finished, Busy); end
   endtask

   task automatic test_timeout();
      clear_opts();
      for (int i = 0; i < 6; i++) model_mem[i] = rand_op();
      model_mem[6] = HALT_OP;
      load_prog();
      build_expected(0, -1);
      run_prog(0, -1, 0, 200);
      checks += 3;
      if (obs_op.size() != 6) begin failures++; $display("FAIL timeout_issues: got %0d want 6", obs_op.size()); end
      if (Pc !== 5'd6) begin failures++; $display("FAIL timeout_pc: got %0d want 6", Pc); end
      if (InstrCount !== 6'd6) begin failures++; $display("FAIL timeout_count: got %0d want 6", InstrCount); end
      for (int i = 1; i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
            failures++; $display("FAIL timeout_gap%0d: got %0d cycles want 4", i, obs_cyc[i] - obs_cyc[i-1]);
         end
      end
   endtask

   task automatic test_load_at_start();
      clear_opts();
      for (int i = 0; i < 3; i++) model_mem[i] = rand_op();
      model_mem[3] = HALT_OP;
      load_prog();
      opt_load_at_start = 1;
      opt_stop_at_start = 1;
      opt_load_val = rand_op();
      model_mem[0] = opt_load_val;
      build_expected(0, -1);
      run_prog(0, -1, 1, 200);
      checks += 3;
      if (obs_op.size() != exp_q.size()) begin
         failures++; $display("FAIL load_start_issues: got %0d want %0d", obs_op.size(), exp_q.size());
      end else if (obs_op[0] !== opt_load_val) begin
         failures++; $display("FAIL load_start_op0: got %h want %h", obs_op[0], opt_load_val);
      end
      if (Pc !== 5'd3) begin failures++; $display("FAIL load_start_pc: got %0d want 3", Pc); end
      if (InstrCount !== 6'd3) begin failures++; $display("FAIL load_start_count: got %0d want 3", InstrCount); end
   endtask

   task automatic test_end_of_ram();
      clear_opts();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_op();
      load_prog();
      run_prog(0, -1, 0, 300);
      checks += 3;
      if (obs_op.size() != DEPTH) begin failures++; $display("FAIL eor_issues: got %0d want %0d", obs_op.size(), DEPTH); end
      if (Pc !== 5'd31) begin failures++; $display("FAIL eor_pc: got %0d want 31", Pc); end
      if (InstrCount !== 6'd32) begin failures++; $display("FAIL eor_count: got %0d want 32", InstrCount); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         int n;
         int plen;
         int sidx;
         clear_opts();
         n = $urandom_range(2, 12);
         for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_op();
         if ($urandom_range(0, 2) == 0) model_mem[$urandom_range(1, n)] = HALT_OP;
         plen = $urandom_range(0, n);
         sidx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, n);
         load_prog();
         build_expected(plen, sidx);
         run_prog(plen, sidx, $urandom_range(0, 4), 2000);
         checks++;
         if (obs_op.size() != exp_q.size()) begin
            failures++; $display("FAIL rand%0d_issues: got %0d want %0d", it, obs_op.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < obs_op.size()) begin
            checks++;
            if (obs_op[i] !== exp_q[i] || obs_pc[i] !== exp_pc_q[i]) begin
               failures++;
               $display("FAIL rand%0d_op%0d: got %h@%0d want %h@%0d", it, i, obs_op[i], obs_pc[i], exp_q[i], exp_pc_q[i]);
            end
         end
         checks += 2;
         if (InstrCount !== (AW+1)'(exp_count)) begin failures++; $display("FAIL rand%0d_count: got %0d want %0d", it, InstrCount, exp_count); end
         if (Pc !== exp_final_pc) begin failures++; $display("FAIL rand%0d_pc: got %0d want %0d", it, Pc, exp_final_pc); end
      end
   endtask

   task automatic test_reset_midrun();
      int k = 0;
      int late_issues = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_op();
      load_prog();
      ProgLen = 6'd5;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      while (Issue !== 1'b1 && k < 20) begin @(negedge Clock); k++; end
      checks++;
      if (Issue !== 1'b1) begin failures++; $display("FAIL midrun_issue: no Issue within 20 cycles"); end
      Done = 1'b0;
      @(negedge Clock);
      ResetN = 1'b0;
      @(negedge Clock);
      checks += 3;
      if (OpCode !== '0 || Issue !== 1'b0 || Pc !== '0) begin
         failures++; $display("FAIL midrun_reset_a: op=%h iss=%b pc=%0d want 0 0 0", OpCode, Issue, Pc);
      end
      if (Busy !== 1'b0 || Finished !== 1'b0) begin
         failures++; $display("FAIL midrun_reset_b: busy=%b fin=%b want 0 0", Busy, Finished);
      end
      if (InstrCount !== '0) begin failures++; $display("FAIL midrun_reset_count: got %0d want 0", InstrCount); end
      ResetN = 1'b1;
      Done = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         if (Issue === 1'b1 || Busy === 1'b1) late_issues++;
      end
      checks++;
      if (late_issues != 0) begin failures++; $display("FAIL midrun_quiet: got %0d active cycles want 0", late_issues); end
   endtask

`ifdef SEQ_LOOP_EN
   task automatic test_loop();
      clear_opts();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_op();
      load_prog();
      build_expected(2, 69);
      run_prog(2, 69, 0, 400);
      checks += 3;
      if (obs_op.size() != 70) begin failures++; $display("FAIL loop_issues: got %0d want 70", obs_op.size()); end
      if (InstrCount !== 6'd63) begin failures++; $display("FAIL loop_count: got %0d want 63", InstrCount); end
      if (Pc !== 5'd1) begin failures++; $display("FAIL loop_pc: got %0d want 1", Pc); end
      foreach (exp_pc_q[i]) if (i < obs_pc.size()) begin
         checks++;
         if (obs_pc[i] !== exp_pc_q[i] || obs_op[i] !== exp_q[i]) begin
            failures++; $display("FAIL loop_op%0d: got %h@%0d want %h@%0d", i, obs_op[i], obs_pc[i], exp_q[i], exp_pc_q[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifndef SEQ_LOOP_EN
      test_basic();
`endif
      test_halt_opcode();
      test_stop();
      test_timeout();
      test_load_at_start();
`ifndef SEQ_LOOP_EN
      test_end_of_ram();
      test_random();
`endif
      test_reset_midrun();
`ifdef SEQ_LOOP_EN
      test_loop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
